mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 200 ++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// ============================================================================
// mul_div_unit : iterative shift-add multiplier / restoring divider, 1 bit/clk
// Optional signed ops when MUL_DIV_SIGNED_EN is defined.    Rev 1.0
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int bit_size = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [bit_size-1:0] src1,
    input  logic [bit_size-1:0] src2,
    output logic                busy,
    output logic                done,
    output logic [bit_size-1:0] hi,
    output logic [bit_size-1:0] lo,
    output logic                div_by_zero
);

    localparam int W  = bit_size;
    localparam int CW = $clog2(bit_size + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W:0]    work_q, work_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            dbz_q, dbz_d;

    logic            accept;
    logic [W-1:0]    mag1, mag2;
    logic [W:0]      mul_upper;
    logic [2*W:0]    mul_next;
    logic [2*W:0]    div_shift;
    logic [W:0]      div_diff;
    logic [2*W:0]    div_next;

`ifdef MUL_DIV_SIGNED_EN
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            sgn1, sgn2;

    always_comb begin
        sgn1 = ~op[0] & src1[W-1];
        sgn2 = ~op[0] & src2[W-1];
        mag1 = sgn1 ? (-src1) : src1;
        mag2 = sgn2 ? (-src2) : src2;
    end
`else
    logic            unused_op0;

    assign unused_op0 = op[0];
    assign mag1       = src1;
    assign mag2       = src2;
`endif

    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

    // Shift-add: work = {partial product (W+1), remaining multiplier bits}
    always_comb begin
        mul_upper = work_q[2*W:W] + {1'b0, (work_q[0] ? opnd_q : {W{1'b0}})};
        mul_next  = {mul_upper, work_q[W-1:0]} >> 1;
    end

    // Restoring divide: work = {partial remainder (W+1), dividend/quotient}
    always_comb begin
        div_shift = work_q << 1;
        div_diff  = div_shift[2*W:W] - {1'b0, opnd_q};
        if (!div_diff[W]) begin
            div_next = {div_diff, div_shift[W-1:1], 1'b1};
        end else begin
            div_next = div_shift;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
`ifdef MUL_DIV_SIGNED_EN
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
`endif

        case (state_q)
            S_MUL: begin
                if (cnt_q == CW'(W)) begin
                    state_d = S_DONE;
`ifdef MUL_DIV_SIGNED_EN
                    {hi_d, lo_d} = neg_res_q ? (-work_q[2*W-1:0]) : work_q[2*W-1:0];
`else
                    {hi_d, lo_d} = work_q[2*W-1:0];
`endif
                end else begin
                    work_d = mul_next;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            S_DIV: begin
                if (opnd_q == '0) begin
                    // Dividend magnitude is still untouched in the low half
                    state_d = S_DONE;
                    lo_d    = '1;
                    dbz_d   = 1'b1;
`ifdef MUL_DIV_SIGNED_EN
                    hi_d    = neg_rem_q ? (-work_q[W-1:0]) : work_q[W-1:0];
`else
                    hi_d    = work_q[W-1:0];
`endif
                end else if (cnt_q == CW'(W)) begin
                    state_d = S_DONE;
`ifdef MUL_DIV_SIGNED_EN
                    lo_d    = neg_res_q ? (-work_q[W-1:0])   : work_q[W-1:0];
                    hi_d    = neg_rem_q ? (-work_q[2*W-1:W]) : work_q[2*W-1:W];
`else
                    lo_d    = work_q[W-1:0];
                    hi_d    = work_q[2*W-1:W];
`endif
                end else begin
                    work_d = div_next;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = op[1] ? S_DIV : S_MUL;
            opnd_d  = op[1] ? mag2 : mag1;
            work_d  = {{(W+1){1'b0}}, (op[1] ? mag1 : mag2)};
`ifdef MUL_DIV_SIGNED_EN
            neg_res_d = sgn1 ^ sgn2;
            neg_rem_d = sgn1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

`ifdef MUL_DIV_SIGNED_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`endif

    assign busy        = (state_q == S_MUL) || (state_q == S_DIV);
    assign done        = (state_q == S_DONE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// tb_mul_div_unit : directed self-checking bench for mul_div_unit (32-bit)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    mul_div_unit #(.bit_size(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .src1        (src1),
        .src2        (src2),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait for its done; returns at posedge+1 of the done cycle
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz, input int elat);
        int  lat;
        logic seen;
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        src1  = $urandom;
        src2  = $urandom;
        check({tag, "/busy_at_accept"}, busy, 1'b1);
        check({tag, "/dbz_cleared"}, div_by_zero, 1'b0);
        check({tag, "/hi_held"}, hi, last_hi);
        check({tag, "/lo_held"}, lo, last_lo);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            check({tag, "/busy_done_excl"}, busy & done, 1'b0);
            if (done) seen = 1'b1;
        end
        check({tag, "/done_seen"}, seen, 1'b1);
        check({tag, "/latency"}, lat, elat);
        check({tag, "/hi"}, hi, ehi);
        check({tag, "/lo"}, lo, elo);
        check({tag, "/dbz"}, div_by_zero, edbz);
        last_hi = ehi;
        last_lo = elo;
    endtask

    initial begin
        int   ndone;
        logic [31:0] cap_hi;
        logic [31:0] cap_lo;

        rst   = 1'b0;
        start = 1'b0;
        op    = 2'd0;
        src1  = '0;
        src2  = '0;
        #12;
        check("reset/busy", busy, 1'b0);
        check("reset/done", done, 1'b0);
        check("reset/hi", hi, 32'h0);
        check("reset/lo", lo, 32'h0);
        check("reset/dbz", div_by_zero, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // First request right after reset release, then back-to-back chain
        run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
`ifdef MUL_DIV_SIGNED_EN
        run_op("mult_m3x7", 2'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33);
`else
        run_op("mult_m3x7", 2'd0, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB, 1'b0, 33);
`endif
        run_op("divu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
`ifdef MUL_DIV_SIGNED_EN
        run_op("div_m7_2", 2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
`else
        run_op("div_m7_2", 2'd2, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 1'b0, 33);
`endif
        run_op("divu_5_0", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1);

        @(posedge clk);
        #1;
        check("done_one_cycle", done, 1'b0);
        check("idle_not_busy", busy, 1'b0);
        check("dbz_held_idle", div_by_zero, 1'b1);

`ifdef MUL_DIV_SIGNED_EN
        run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33);
        run_op("mult_m1xm1", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33);
        run_op("div_7_m2", 2'd2, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33);
`else
        run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 33);
        run_op("mult_m1xm1", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
        run_op("div_7_m2", 2'd2, 32'd7, 32'hFFFFFFFE, 32'h00000007, 32'h00000000, 1'b0, 33);
`endif
        run_op("mult_minneg_sq", 2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33);
        run_op("div_m5_0", 2'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1);
        run_op("multu_shift", 2'd1, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 1'b0, 33);
        run_op("divu_max_1", 2'd3, 32'hFFFFFFFF, 32'd1, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33);
        run_op("divu_3_10", 2'd3, 32'd3, 32'd10, 32'd3, 32'd0, 1'b0, 33);

        // Start re-pulsed while busy must be ignored
        @(negedge clk);
        start = 1'b1;
        op    = 2'd1;
        src1  = 32'd6;
        src2  = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'd3;
        src1  = 32'd100;
        src2  = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("repulse/busy", busy, 1'b1);
        ndone  = 0;
        cap_hi = 32'hDEADBEEF;
        cap_lo = 32'hDEADBEEF;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                cap_hi = hi;
                cap_lo = lo;
            end
        end
        check("repulse/ndone", ndone, 1);
        check("repulse/hi", cap_hi, 32'd0);
        check("repulse/lo", cap_lo, 32'd42);
        check("repulse/dbz", div_by_zero, 1'b0);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1;
        op    = 2'd1;
        src1  = 32'hFFFFFFFF;
        src2  = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("abort/busy", busy, 1'b0);
        check("abort/done", done, 1'b0);
        check("abort/hi", hi, 32'd0);
        check("abort/lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort/no_done", ndone, 0);
        last_hi = '0;
        last_lo = '0;
        run_op("after_abort", 2'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
